// File: rtl/wb_arb_pkg.sv
// Shared constants, FSM state type and owner-selection helper for the
// two-requester wishbone command arbiter.
package wb_arb_pkg;

    localparam int CMD_W = 34;

    localparam logic [CMD_W-1:0] DEF_ERR_WORD = 34'h3_DEADBEEF;

    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    // Sole valid slot wins; a tie goes to the port that was not served last.
    function automatic logic pick_owner(input logic [1:0] valid, input logic rr_last);
        logic sel;
        if (valid == 2'b11) begin
            sel = ~rr_last;
        end else if (valid[DATA]) begin
            sel = DATA;
        end else begin
            sel = FETCH;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Requester-side and wishbone-master-side signals of the arbiter.
// slave = arbiter view, master = view of the surrounding logic.
interface wb_mem_arbiter_if;
    import wb_arb_pkg::*;

    logic             cmd_stb0;
    logic [CMD_W-1:0] cmd_word0;
    logic             cmd_busy0;
    logic             rsp_stb0;
    logic [CMD_W-1:0] rsp_word0;

    logic             cmd_stb1;
    logic [CMD_W-1:0] cmd_word1;
    logic             cmd_busy1;
    logic             rsp_stb1;
    logic [CMD_W-1:0] rsp_word1;

    logic             cmd_stb;
    logic [CMD_W-1:0] cmd_word;
    logic             cmd_busy;
    logic             rsp_stb;
    logic [CMD_W-1:0] rsp_word;

    logic             timeout_err;

    modport slave (
        input  cmd_stb0, cmd_word0, cmd_stb1, cmd_word1,
        input  cmd_busy, rsp_stb, rsp_word,
        output cmd_busy0, rsp_stb0, rsp_word0,
        output cmd_busy1, rsp_stb1, rsp_word1,
        output cmd_stb, cmd_word, timeout_err
    );

    modport master (
        output cmd_stb0, cmd_word0, cmd_stb1, cmd_word1,
        output cmd_busy, rsp_stb, rsp_word,
        input  cmd_busy0, rsp_stb0, rsp_word0,
        input  cmd_busy1, rsp_stb1, rsp_word1,
        input  cmd_stb, cmd_word, timeout_err
    );

endinterface

// File: rtl/wb_arb_slot.sv
// One-entry command slot: captures a strobed word while not busy and keeps
// the requester busy until its response has been delivered.
module wb_arb_slot
    import wb_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stb,
    input  logic [CMD_W-1:0] word,
    input  logic             clear_valid,
    input  logic             release_busy,
    output logic             valid,
    output logic [CMD_W-1:0] held_word,
    output logic             busy
);

    logic             valid_r;
    logic             busy_r;
    logic [CMD_W-1:0] word_r;
    logic             capture_s;

    assign capture_s = stb & ~busy_r;

    // Capture, issue-clear and release of the slot; valid implies busy, so a
    // capture never coincides with a clear or a release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            word_r  <= {CMD_W{1'b0}};
        end else if (capture_s) begin
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            word_r  <= word;
        end else begin
            if (clear_valid) begin
                valid_r <= 1'b0;
            end
            if (release_busy) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign valid     = valid_r;
    assign held_word = word_r;
    assign busy      = busy_r;

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one wishbone master between instruction fetch
// (port 0) and data (port 1). Optional response timeout: WB_MEM_ARBITER_TIMEOUT_EN.
module wb_mem_arbiter
    import wb_arb_pkg::*;
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
#(
    parameter int unsigned      TIMEOUT_CYCLES = 32'd255,
    parameter logic [CMD_W-1:0] ERR_WORD       = DEF_ERR_WORD
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    wb_mem_arbiter_if.slave  bus
);

    arb_state_t       state_r;
    arb_state_t       state_s;
    logic             owner_r;
    logic             owner_s;
    logic             rr_last_r;

    logic [1:0]       slot_valid_s;
    logic [1:0]       slot_busy_s;
    logic [1:0]       clear_valid_s;
    logic [CMD_W-1:0] slot_word0_s;
    logic [CMD_W-1:0] slot_word1_s;
    logic [CMD_W-1:0] owner_word_s;

    logic             cmd_stb_s;
    logic             rsp_take_s;
    logic             tmo_fire_s;
    logic             timeout_s;
    logic             done_s;
    logic [CMD_W-1:0] err_word_s;
    logic [CMD_W-1:0] done_word_s;

    logic [1:0]       rsp_stb_r;
    logic [CMD_W-1:0] rsp_word0_r;
    logic [CMD_W-1:0] rsp_word1_r;
    logic [CMD_W-1:0] cmd_word_r;

    wb_arb_slot u_slot_fetch (
        .clk          (clk),
        .reset        (reset),
        .stb          (bus.cmd_stb0),
        .word         (bus.cmd_word0),
        .clear_valid  (clear_valid_s[FETCH]),
        .release_busy (rsp_stb_r[FETCH]),
        .valid        (slot_valid_s[FETCH]),
        .held_word    (slot_word0_s),
        .busy         (slot_busy_s[FETCH])
    );

    wb_arb_slot u_slot_data (
        .clk          (clk),
        .reset        (reset),
        .stb          (bus.cmd_stb1),
        .word         (bus.cmd_word1),
        .clear_valid  (clear_valid_s[DATA]),
        .release_busy (rsp_stb_r[DATA]),
        .valid        (slot_valid_s[DATA]),
        .held_word    (slot_word1_s),
        .busy         (slot_busy_s[DATA])
    );

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 32'd255) ? 16 : 8;

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_err_r;

    assign timeout_s  = (state_r == WAIT_RSP) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES));
    assign err_word_s = ERR_WORD;

    // Response-wait counter: zero outside WAIT_RSP, so it restarts on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r != WAIT_RSP) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err_r <= 1'b0;
        end else if (tmo_fire_s) begin
            timeout_err_r <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_err_r;
`else
    assign timeout_s       = 1'b0;
    assign err_word_s      = DEF_ERR_WORD;
    assign bus.timeout_err = 1'b0;
`endif

    // Word of the slot currently owning the bus.
    always_comb begin
        owner_word_s = slot_word0_s;
        if (owner_r == DATA) begin
            owner_word_s = slot_word1_s;
        end else begin
            owner_word_s = slot_word0_s;
        end
    end

    // FSM state and owner registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            owner_r <= FETCH;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
        end
    end

    // Next-state logic; a real response in the expiry cycle beats the timeout.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        cmd_stb_s  = 1'b0;
        rsp_take_s = 1'b0;
        tmo_fire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|slot_valid_s) begin
                    state_s = ISSUE;
                    owner_s = pick_owner(slot_valid_s, rr_last_r);
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (!bus.cmd_busy) begin
                    cmd_stb_s = 1'b1;
                    state_s   = WAIT_RSP;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT_RSP: begin
                if (bus.rsp_stb) begin
                    rsp_take_s = 1'b1;
                    state_s    = IDLE;
                end else if (timeout_s) begin
                    tmo_fire_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s = WAIT_RSP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign done_s      = rsp_take_s | tmo_fire_s;
    assign done_word_s = rsp_take_s ? bus.rsp_word : err_word_s;

    // The issuing slot drops valid when the bus accepts its command.
    always_comb begin
        clear_valid_s = 2'b00;
        if (cmd_stb_s) begin
            clear_valid_s[owner_r] = 1'b1;
        end else begin
            clear_valid_s = 2'b00;
        end
    end

    // Response routing, round-robin history and held bus command word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_stb_r   <= 2'b00;
            rsp_word0_r <= {CMD_W{1'b0}};
            rsp_word1_r <= {CMD_W{1'b0}};
            cmd_word_r  <= {CMD_W{1'b0}};
            rr_last_r   <= 1'b1;
        end else begin
            rsp_stb_r <= 2'b00;
            if (state_r == ISSUE) begin
                cmd_word_r <= owner_word_s;
            end
            if (done_s) begin
                rr_last_r <= owner_r;
                if (owner_r == DATA) begin
                    rsp_stb_r   <= 2'b10;
                    rsp_word1_r <= done_word_s;
                end else begin
                    rsp_stb_r   <= 2'b01;
                    rsp_word0_r <= done_word_s;
                end
            end
        end
    end

    assign bus.cmd_stb   = cmd_stb_s;
    assign bus.cmd_word  = (state_r == ISSUE) ? owner_word_s : cmd_word_r;
    assign bus.cmd_busy0 = slot_busy_s[FETCH];
    assign bus.cmd_busy1 = slot_busy_s[DATA];
    assign bus.rsp_stb0  = rsp_stb_r[FETCH];
    assign bus.rsp_stb1  = rsp_stb_r[DATA];
    assign bus.rsp_word0 = rsp_word0_r;
    assign bus.rsp_word1 = rsp_word1_r;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_wb_mem_arbiter;
    import wb_arb_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_mem_arbiter_if ifc();

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
    localparam int TMO = 8;
    wb_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_WORD(34'h3_DEADBEEF)) dut (
        .clk(clk), .reset(reset), .bus(ifc));
`else
    wb_mem_arbiter dut (.clk(clk), .reset(reset), .bus(ifc));
`endif

    // Reference state: what each requester holds, who owns the bus, and
    // whether the owner's command is still being offered or already sent.
    typedef struct packed {
        logic [1:0]        pend;
        logic [1:0]        busy;
        logic [1:0]        rstb;
        logic [1:0][33:0]  slotw;
        logic [1:0][33:0]  rword;
        logic [33:0]       lastcmd;
        logic              granted;
        logic              outstanding;
        logic              own;
        logic              rr;
        logic              terr;
        int unsigned       waited;
    } model_t;

    model_t m;
    int checks   = 0;
    int failures = 0;
    int ngr;
    int rsp_due;
    int cnt;
    int order [6];

    function automatic model_t model_reset();
        model_t r;
        r    = '0;
        r.rr = 1'b1;
        return r;
    endfunction

    function automatic model_t model_next(input model_t cur,
                                          input logic s0, input logic [33:0] w0,
                                          input logic s1, input logic [33:0] w1,
                                          input logic cbusy, input logic rs,
                                          input logic [33:0] rw);
        model_t n;
        logic   deliver;
        logic [33:0] dword;
        n       = cur;
        n.rstb  = 2'b00;
        deliver = 1'b0;
        dword   = rw;
        for (int p = 0; p < 2; p++) begin
            if (cur.rstb[p]) n.busy[p] = 1'b0;
        end
        if (s0 && !cur.busy[0]) begin n.pend[0] = 1'b1; n.busy[0] = 1'b1; n.slotw[0] = w0; end
        if (s1 && !cur.busy[1]) begin n.pend[1] = 1'b1; n.busy[1] = 1'b1; n.slotw[1] = w1; end
        if (cur.granted) begin
            if (!cbusy) begin
                n.lastcmd       = cur.slotw[cur.own];
                n.pend[cur.own] = 1'b0;
                n.granted       = 1'b0;
                n.outstanding   = 1'b1;
                n.waited        = 0;
            end
        end else if (cur.outstanding) begin
            if (rs) begin
                deliver = 1'b1;
            end
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
            else if (cur.waited == TMO) begin
                deliver = 1'b1;
                dword   = 34'h3_DEADBEEF;
                n.terr  = 1'b1;
            end
`endif
            else begin
                n.waited = cur.waited + 1;
            end
        end else if (cur.pend != 2'b00) begin
            n.granted = 1'b1;
            n.own     = (cur.pend == 2'b11) ? ~cur.rr : cur.pend[1];
        end
        if (deliver) begin
            n.rstb[cur.own]  = 1'b1;
            n.rword[cur.own] = dword;
            n.rr             = cur.own;
            n.outstanding    = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= model_reset();
        else m <= model_next(m, ifc.cmd_stb0, ifc.cmd_word0, ifc.cmd_stb1, ifc.cmd_word1,
                             ifc.cmd_busy, ifc.rsp_stb, ifc.rsp_word);
    end

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic        exp_stb;
        logic [33:0] exp_word;
        exp_stb  = m.granted & ~ifc.cmd_busy;
        exp_word = m.granted ? m.slotw[m.own] : m.lastcmd;
        chk("cmd_busy0",   34'(ifc.cmd_busy0),   34'(m.busy[0]));
        chk("cmd_busy1",   34'(ifc.cmd_busy1),   34'(m.busy[1]));
        chk("rsp_stb0",    34'(ifc.rsp_stb0),    34'(m.rstb[0]));
        chk("rsp_stb1",    34'(ifc.rsp_stb1),    34'(m.rstb[1]));
        chk("rsp_word0",   ifc.rsp_word0,        m.rword[0]);
        chk("rsp_word1",   ifc.rsp_word1,        m.rword[1]);
        chk("cmd_stb",     34'(ifc.cmd_stb),     34'(exp_stb));
        chk("cmd_word",    ifc.cmd_word,         exp_word);
        chk("timeout_err", 34'(ifc.timeout_err), 34'(m.terr));
    endtask

    task automatic sample();  @(negedge clk); compare_all(); endtask
    task automatic advance(); @(posedge clk); #1;            endtask
    task automatic step();    sample(); advance();           endtask

    task automatic idle_inputs();
        ifc.cmd_stb0 = 1'b0; ifc.cmd_word0 = 34'd0;
        ifc.cmd_stb1 = 1'b0; ifc.cmd_word1 = 34'd0;
        ifc.cmd_busy = 1'b0; ifc.rsp_stb   = 1'b0; ifc.rsp_word = 34'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        sample();
        chk("rst_zero", {ifc.cmd_busy0, ifc.cmd_busy1, ifc.rsp_stb0, ifc.rsp_stb1,
                         ifc.cmd_stb, ifc.timeout_err, 28'd0}, 34'd0);
        chk("rst_words", ifc.rsp_word0 | ifc.rsp_word1 | ifc.cmd_word, 34'd0);
        advance();
        reset = 1'b1;
    endtask

    function automatic logic [33:0] rand_word();
        logic [1:0] hi;
        hi = 2'($urandom_range(0, 3));
        return {hi, $urandom()};
    endfunction

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Single fetch with the bus idle.
        do_reset();
        ifc.cmd_stb0 = 1'b1; ifc.cmd_word0 = 34'h0_00000010; step(); ifc.cmd_stb0 = 1'b0;
        step();
        sample();
        chk("t1_cmd_stb", 34'(ifc.cmd_stb), 34'd1);
        chk("t1_cmd_word", ifc.cmd_word, 34'h0_00000010);
        advance();
        step(); step();
        ifc.rsp_stb = 1'b1; ifc.rsp_word = 34'h0_00500093; step(); ifc.rsp_stb = 1'b0;
        sample();
        chk("t1_rsp_stb0", 34'(ifc.rsp_stb0), 34'd1);
        chk("t1_rsp_word0", ifc.rsp_word0, 34'h0_00500093);
        chk("t1_rsp_stb1", 34'(ifc.rsp_stb1), 34'd0);
        advance();
        sample();
        chk("t1_busy0_free", 34'(ifc.cmd_busy0), 34'd0);
        advance();

        // Simultaneous strobes: port 0 first, port 1 after its response.
        do_reset();
        ifc.cmd_stb0 = 1'b1; ifc.cmd_word0 = 34'h1_000000AA;
        ifc.cmd_stb1 = 1'b1; ifc.cmd_word1 = 34'h2_000000BB;
        step();
        ifc.cmd_stb0 = 1'b0; ifc.cmd_stb1 = 1'b0;
        step();
        sample(); chk("t2_first_word", ifc.cmd_word, 34'h1_000000AA);
        chk("t2_first_stb", 34'(ifc.cmd_stb), 34'd1); advance();
        step();
        ifc.rsp_stb = 1'b1; ifc.rsp_word = 34'h0_0000C0DE; step(); ifc.rsp_stb = 1'b0;
        sample(); chk("t2_rsp0", 34'({ifc.rsp_stb0, ifc.rsp_stb1}), 34'd2); advance();
        sample(); chk("t2_second_word", ifc.cmd_word, 34'h2_000000BB);
        chk("t2_second_stb", 34'(ifc.cmd_stb), 34'd1); advance();
        ifc.rsp_stb = 1'b1; ifc.rsp_word = 34'h3_0000D00D; step(); ifc.rsp_stb = 1'b0;
        sample(); chk("t2_rsp1", 34'({ifc.rsp_stb0, ifc.rsp_stb1}), 34'd1);
        chk("t2_rsp_word1", ifc.rsp_word1, 34'h3_0000D00D); advance();

        // Round-robin with both slots kept full.
        do_reset();
        ngr = 0; rsp_due = -1;
        for (int c = 0; c < 200 && ngr < 6; c++) begin
            ifc.cmd_stb0 = 1'b1; ifc.cmd_word0 = {2'b00, 32'hA000_0000 + 32'(c)};
            ifc.cmd_stb1 = 1'b1; ifc.cmd_word1 = {2'b01, 32'hB000_0000 + 32'(c)};
            ifc.rsp_stb  = (rsp_due == 0); ifc.rsp_word = {2'b10, 32'(c)};
            if (rsp_due >= 0) rsp_due--;
            sample();
            if (ifc.cmd_stb) begin
                order[ngr] = int'(ifc.cmd_word[32]);
                ngr++;
                rsp_due = 2;
            end
            advance();
        end
        idle_inputs();
        chk("rr_grants", 34'(ngr), 34'd6);
        for (int i = 0; i < 6; i++) chk("rr_order", 34'(order[i]), 34'(i % 2));

        // Backpressure, ignored re-strobe, spurious response.
        do_reset();
        ifc.cmd_stb0 = 1'b1; ifc.cmd_word0 = 34'h0_12345678; step(); ifc.cmd_stb0 = 1'b0;
        ifc.cmd_busy = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin ifc.cmd_stb0 = 1'b1; ifc.cmd_word0 = 34'h3_FFFF0000; end
            sample(); chk("bp_hold", 34'(ifc.cmd_stb), 34'd0); advance();
            ifc.cmd_stb0 = 1'b0;
        end
        ifc.cmd_busy = 1'b0;
        sample(); chk("bp_release", 34'(ifc.cmd_stb), 34'd1);
        chk("bp_word", ifc.cmd_word, 34'h0_12345678); advance();
        sample(); chk("bp_single", 34'(ifc.cmd_stb), 34'd0); advance();
        ifc.rsp_stb = 1'b1; ifc.rsp_word = 34'h1_0BADF00D; step(); ifc.rsp_stb = 1'b0;
        sample(); chk("bp_rsp_word0", ifc.rsp_word0, 34'h1_0BADF00D); advance();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin sample(); if (ifc.cmd_stb) cnt++; advance(); end
        chk("no_extra_cmd", 34'(cnt), 34'd0);
        ifc.rsp_stb = 1'b1; ifc.rsp_word = 34'h2_22222222; step(); ifc.rsp_stb = 1'b0;
        sample(); chk("spurious_rsp", 34'({ifc.rsp_stb0, ifc.rsp_stb1}), 34'd0);
        chk("rsp_word0_hold", ifc.rsp_word0, 34'h1_0BADF00D); advance();

        // Reset while a transaction is outstanding.
        do_reset();
        ifc.cmd_stb1 = 1'b1; ifc.cmd_word1 = 34'h2_00C0FFEE; step(); ifc.cmd_stb1 = 1'b0;
        step(); step();
        reset = 1'b0;
        sample();
        chk("mid_rst_busy1", 34'(ifc.cmd_busy1), 34'd0);
        chk("mid_rst_cmd", {ifc.cmd_stb, ifc.cmd_word[32:0]}, 34'd0);
        advance();
        reset = 1'b1;
        ifc.rsp_stb = 1'b1; ifc.rsp_word = 34'h1_11111111; step(); ifc.rsp_stb = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin sample(); if (ifc.rsp_stb1 || ifc.rsp_stb0) cnt++; advance(); end
        chk("no_rsp_after_rst", 34'(cnt), 34'd0);

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
        // No response: error word delivered once, sticky flag, late response dropped.
        do_reset();
        ifc.cmd_stb0 = 1'b1; ifc.cmd_word0 = 34'h0_00000040; step(); ifc.cmd_stb0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (ifc.rsp_stb0) begin cnt++; chk("tmo_word", ifc.rsp_word0, 34'h3_DEADBEEF); end
            advance();
        end
        chk("tmo_pulses", 34'(cnt), 34'd1);
        chk("tmo_flag", 34'(ifc.timeout_err), 34'd1);
        ifc.rsp_stb = 1'b1; ifc.rsp_word = 34'h0_00000001; step(); ifc.rsp_stb = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin sample(); if (ifc.rsp_stb0) cnt++; advance(); end
        chk("tmo_late_drop", 34'(cnt), 34'd0);
        chk("tmo_sticky", 34'(ifc.timeout_err), 34'd1);
`endif

        // Random traffic, backpressure, stray responses and rare resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ifc.cmd_stb0 = ($urandom_range(0, 3) == 0); ifc.cmd_word0 = rand_word();
            ifc.cmd_stb1 = ($urandom_range(0, 3) == 0); ifc.cmd_word1 = rand_word();
            ifc.cmd_busy = ($urandom_range(0, 2) == 0);
            ifc.rsp_stb  = ($urandom_range(0, 3) == 0); ifc.rsp_word  = rand_word();
            reset        = ($urandom_range(0, 999) != 0);
            step();
        end
        reset = 1'b1;
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Shares the single wishbone master command/response interface (cmd_stb/cmd_word/cmd_busy/rsp_stb/rsp_word) between two requesters: port 0 is instruction fetch, port 1 is data load/store.
- Sits between controller/datapath and the wishbone master.
- Buffers one command per requester and arbitrates round-robin.
- Allows one outstanding bus transaction at a time and routes each response back to the requester that issued it.

Parameters:
- CMD_W, 34, width of command and response words.
- TIMEOUT_CYCLES, 255, cycles in WAIT_RSP before a timeout fires (used only with the optional feature).
- ERR_WORD, 34'h3_DEADBEEF, response word returned on timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_stb0  in  1  requester 0 command strobe, single-cycle.
- cmd_word0  in  CMD_W  requester 0 command.
- cmd_busy0  out  1  requester 0 may not strobe.
- rsp_stb0  out  1  requester 0 response strobe, single-cycle.
- rsp_word0  out  CMD_W  requester 0 response.
- cmd_stb1, cmd_word1, cmd_busy1, rsp_stb1, rsp_word1: same as port 0, for requester 1.
- cmd_stb  out  1  command strobe to wishbone master.
- cmd_word  out  CMD_W  command to wishbone master.
- cmd_busy  in  1  wishbone master cannot accept a command.
- rsp_stb  in  1  wishbone master response strobe.
- rsp_word  in  CMD_W  wishbone master response.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; both slots empty.
  - cmd_busy0/1=0, rsp_stb0/1=0, rsp_word0/1=0, cmd_stb=0, cmd_word=0, timeout_err=0.
  - rr_last=1, so port 0 wins the first tie.
  - Reset mid-transaction discards pending and outstanding commands; no response is delivered.
- Slot capture:
  - cmd_stbN with cmd_busyN=0 latches cmd_wordN into slot N.
  - cmd_busyN goes 1 the next cycle and stays 1 until the cycle after rsp_stbN.
  - cmd_stbN while cmd_busyN=1 is ignored; the slot word is unchanged.
  - Simultaneous strobes on both ports are both captured.
- FSM states: IDLE, ISSUE, WAIT_RSP.
  - IDLE -> ISSUE when any slot is valid. Owner is the sole valid slot; if both are valid, owner = !rr_last.
  - ISSUE: cmd_stb = !cmd_busy (combinational) and cmd_word = slot[owner].
    - If cmd_busy=1, hold with cmd_stb=0.
    - When cmd_stb=1: clear slot valid (cmd_busy[owner] stays high), go to WAIT_RSP.
  - WAIT_RSP: on rsp_stb, register rsp_word into rsp_word[owner] and pulse rsp_stb[owner] for exactly one cycle the next cycle.
    - Then set rr_last=owner and go to IDLE.
- cmd_word holds its last value outside ISSUE.
- rsp_wordN holds its last value between strobes.
- rsp_stb in IDLE or ISSUE (spurious or late) is dropped.
- Minimum latency with bus idle:
  - cmd_stbN at cycle 0.
  - cmd_stb at cycle 2.
  - rsp_stb at cycle k gives rsp_stbN at cycle k+1.
  - A new command may be accepted at cycle k+2.
- The other slot may be captured at any time; it is issued after the current transaction completes.

Optional Feature:
- Macro: WB_MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to WAIT_RSP and increments each cycle.
  - When it reaches TIMEOUT_CYCLES without rsp_stb, deliver rsp_stb[owner] with rsp_word[owner]=ERR_WORD, set timeout_err=1 (sticky until reset), and go to IDLE.
  - rsp_stb in the same cycle as expiry wins; it is a normal response and the timeout is not flagged.
- Not defined: no counter; timeout_err is tied 0; WAIT_RSP waits indefinitely.

Decomposition:
- Package wb_arb_pkg: CMD_W constant, state enum (IDLE/ISSUE/WAIT_RSP), default ERR_WORD, port index constants FETCH=0 and DATA=1.
- Sub-module wb_arb_slot, one-entry command capture slot instantiated twice.
  - Inputs: stb, word, clear_valid, release_busy.
  - Outputs: valid, word, busy.

Test Plan:
- Single fetch, bus idle: cmd_stb0 with word 34'h0_00000010 at cycle 0 -> cmd_stb=1 with same word at cycle 2; rsp_stb with 34'h0_00500093 at cycle 5 -> rsp_stb0=1 with that word at cycle 6; cmd_busy0=0 at cycle 7.
- Simultaneous strobes after reset: cmd_stb0 and cmd_stb1 at cycle 0 -> port 0 issued first, port 1 issued after port 0's response; port 1 never receives rsp_stb during port 0's transaction.
- Round-robin: keep both slots refilled for 6 transactions -> grant order 0,1,0,1,0,1.
- Backpressure: cmd_busy=1 for 4 cycles in ISSUE -> cmd_stb stays 0, then a single-cycle cmd_stb when cmd_busy drops; the slot word is unchanged.
- Protocol: cmd_stb0 while cmd_busy0=1 -> ignored, no extra bus command. Spurious rsp_stb in IDLE -> no rsp_stbN. Reset asserted in WAIT_RSP -> all outputs zero, no rsp_stbN afterwards.
- With WB_MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: no rsp_stb -> rsp_stbN with 34'h3_DEADBEEF, timeout_err=1 held. A late rsp_stb after the timeout is dropped.
